// File: rtl/scd_pkg.sv
// Shared types for the SCD trap-cycle sequencer.
// Trap code bit 1 is the arithmetic overflow request; bit 2 is pushdown overflow.
package scd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CYCLE,
        CLEAR
    } trapState_t;

    localparam logic [8:0] TRAP_BASE = 9'o420;

    typedef logic [1:2] trapCode_t;

    // REQ1 selects location 421, REQ2 selects 422, both select 423.
    function automatic logic [8:0] trap_adr(trapCode_t c);
        return TRAP_BASE | {7'd0, c[2], c[1]};
    endfunction

endpackage

// File: rtl/scd_trap_seq_if.sv
// Request/acknowledge bundle between the SCD flags, the EBOX microcode
// and the trap-cycle sequencer.
interface scd_trap_seq_if;
    logic       trapReq1;
    logic       trapReq2;
    logic       trapEn;
    logic       user;
    logic       nicond;
    logic       intReq;
    logic       pageFail;
    logic       cycDone;
    logic       trapCyc1;
    logic       trapCyc2;
    logic [8:0] trapAdr;
    logic       trapUser;
    logic [1:0] clrReq;
    logic       trapHung;

    modport master (
        output trapReq1, trapReq2, trapEn, user, nicond,
        output intReq, pageFail, cycDone,
        input  trapCyc1, trapCyc2, trapAdr, trapUser,
        input  clrReq, trapHung
    );

    modport slave (
        input  trapReq1, trapReq2, trapEn, user, nicond,
        input  intReq, pageFail, cycDone,
        output trapCyc1, trapCyc2, trapAdr, trapUser,
        output clrReq, trapHung
    );
endinterface

// File: rtl/scd_trap_seq.sv
// SCD trap-cycle sequencer: holds overflow trap requests until an
// instruction boundary, runs the trap cycle, then clears the SCD flags.
module scd_trap_seq
    import scd_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          CROBAR,
    scd_trap_seq_if.slave bus
);

    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

    trapState_t state, state_n;
    trapCode_t  pend, pend_n;
    trapCode_t  code, code_n;
    trapCode_t  req, pend_all;
    logic       user_q, user_n;
    logic [7:0] cnt, cnt_n;
    logic       hung, hung_n;
    logic       take;

    trapCode_t  cyc_q, cyc_n;
    logic [8:0] adr_q, adr_n;
    logic [1:0] clr_q, clr_n;

    always_comb begin
        req      = {bus.trapReq1, bus.trapReq2};
        pend_all = pend | req;
        take     = (pend_all != '0) && bus.nicond
                   && bus.trapEn && !bus.intReq;
        state_n  = state;
        pend_n   = pend_all;
        code_n   = code;
        user_n   = user_q;
        cnt_n    = cnt;
        hung_n   = hung;

        unique case (state)
            IDLE, ARMED: begin
                if (take) begin
                    // Same-cycle requests are bypassed into code, so
                    // nothing is left behind in pend.
                    state_n = CYCLE;
                    code_n  = pend_all;
                    user_n  = bus.user;
                    pend_n  = '0;
                    cnt_n   = '0;
                end else if (pend_all != '0) begin
                    state_n = ARMED;
                end else begin
                    state_n = IDLE;
                end
            end
            CYCLE: begin
                if (bus.pageFail) begin
                    state_n = ARMED;
                    pend_n  = pend_all | code;
                    code_n  = '0;
                end else if (bus.cycDone) begin
                    state_n = CLEAR;
                end else if (cnt == CNT_MAX) begin
                    hung_n  = 1'b1;
                    code_n  = '0;
                    state_n = (pend_all != '0) ? ARMED : IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            CLEAR: begin
                code_n  = '0;
                state_n = (pend_all != '0) ? ARMED : IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        cyc_n = '0;
        adr_n = '0;
        clr_n = '0;
        if (state_n == CYCLE) begin
            cyc_n = code_n;
            adr_n = trap_adr(code_n);
        end
        if (state_n == CLEAR) begin
            clr_n = code_n;
        end
    end

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state  <= IDLE;
            pend   <= '0;
            code   <= '0;
            user_q <= 1'b0;
            cnt    <= '0;
            hung   <= 1'b0;
            cyc_q  <= '0;
            adr_q  <= '0;
            clr_q  <= '0;
        end else begin
            state  <= state_n;
            pend   <= pend_n;
            code   <= code_n;
            user_q <= user_n;
            cnt    <= cnt_n;
            hung   <= hung_n;
            cyc_q  <= cyc_n;
            adr_q  <= adr_n;
            clr_q  <= clr_n;
        end
    end

    // These drive the iSCD trap cycle and flag-clear lines.
    assign bus.trapCyc1 = cyc_q[1];
    assign bus.trapCyc2 = cyc_q[2];
    assign bus.trapAdr  = adr_q;
    assign bus.trapUser = user_q;
    assign bus.clrReq   = clr_q;
    assign bus.trapHung = hung;

endmodule

// File: tb/tb_scd_trap_seq.sv
// Directed testbench for scd_trap_seq.
// Outputs are packed as {cyc1, cyc2, adr[8:0], user, clr[1:0], hung}.
module tb_scd_trap_seq;

    logic clk = 1'b0;
    logic CROBAR;
    int   checks = 0;
    int   failures = 0;

    scd_trap_seq_if bus();

    scd_trap_seq #(.TIMEOUT(4)) dut (
        .clk    (clk),
        .CROBAR (CROBAR),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    logic [14:0] obs;
    assign obs = {bus.trapCyc1, bus.trapCyc2, bus.trapAdr,
                  bus.trapUser, bus.clrReq, bus.trapHung};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        CROBAR       = 1'b1;
        bus.trapReq1 = 1'b0;
        bus.trapReq2 = 1'b0;
        bus.trapEn   = 1'b1;
        bus.user     = 1'b0;
        bus.nicond   = 1'b0;
        bus.intReq   = 1'b0;
        bus.pageFail = 1'b0;
        bus.cycDone  = 1'b0;
        tick();
        tick();
        CROBAR = 1'b0;
        checks++;
        if (obs !== 15'h0) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", obs, 15'h0);
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [14:0] e;
        bus.user     = 1'b1;
        bus.trapReq1 = 1'b1;
        tick();
        bus.trapReq1 = 1'b0;
        tick();
        tick();
        bus.nicond = 1'b1;
        tick();
        bus.nicond = 1'b0;
        e = {1'b1, 1'b0, 9'o421, 1'b1, 2'b00, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL ovf_cycle got=%h exp=%h", obs, e);
        end
        tick();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL ovf_hold got=%h exp=%h", obs, e);
        end
        bus.cycDone = 1'b1;
        tick();
        bus.cycDone = 1'b0;
        e = {1'b0, 1'b0, 9'o000, 1'b1, 2'b10, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL ovf_clr got=%h exp=%h", obs, e);
        end
        tick();
        e = {1'b0, 1'b0, 9'o000, 1'b1, 2'b00, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL ovf_idle got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_both();
        logic [14:0] e;
        bus.user     = 1'b0;
        bus.trapReq1 = 1'b1;
        bus.trapReq2 = 1'b1;
        tick();
        bus.trapReq1 = 1'b0;
        bus.trapReq2 = 1'b0;
        bus.nicond   = 1'b1;
        tick();
        bus.nicond = 1'b0;
        e = {1'b1, 1'b1, 9'o423, 1'b0, 2'b00, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL both_cycle got=%h exp=%h", obs, e);
        end
        bus.cycDone = 1'b1;
        tick();
        bus.cycDone = 1'b0;
        e = {1'b0, 1'b0, 9'o000, 1'b0, 2'b11, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL both_clr got=%h exp=%h", obs, e);
        end
        tick();
        checks++;
        if (obs !== 15'h0) begin
            failures++;
            $display("FAIL both_idle got=%h exp=%h", obs, 15'h0);
        end
    endtask

    task automatic test_int_priority();
        logic [14:0] e;
        bus.trapReq2 = 1'b1;
        tick();
        bus.trapReq2 = 1'b0;
        bus.nicond   = 1'b1;
        bus.intReq   = 1'b1;
        tick();
        bus.nicond = 1'b0;
        bus.intReq = 1'b0;
        checks++;
        if (obs !== 15'h0) begin
            failures++;
            $display("FAIL int_blocked got=%h exp=%h", obs, 15'h0);
        end
        bus.user   = 1'b1;
        bus.nicond = 1'b1;
        tick();
        bus.nicond = 1'b0;
        e = {1'b0, 1'b1, 9'o422, 1'b1, 2'b00, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL int_taken got=%h exp=%h", obs, e);
        end
        bus.cycDone = 1'b1;
        tick();
        bus.cycDone = 1'b0;
        e = {1'b0, 1'b0, 9'o000, 1'b1, 2'b01, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL int_clr got=%h exp=%h", obs, e);
        end
        tick();
    endtask

    task automatic test_page_fail();
        logic [14:0] e;
        bus.trapReq1 = 1'b1;
        tick();
        bus.trapReq1 = 1'b0;
        bus.nicond   = 1'b1;
        tick();
        bus.nicond   = 1'b0;
        bus.pageFail = 1'b1;
        bus.cycDone  = 1'b1;
        tick();
        bus.pageFail = 1'b0;
        bus.cycDone  = 1'b0;
        e = {1'b0, 1'b0, 9'o000, 1'b1, 2'b00, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL pf_abort got=%h exp=%h", obs, e);
        end
        tick();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL pf_noclr got=%h exp=%h", obs, e);
        end
        bus.nicond = 1'b1;
        tick();
        bus.nicond = 1'b0;
        e = {1'b1, 1'b0, 9'o421, 1'b1, 2'b00, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL pf_retry got=%h exp=%h", obs, e);
        end
        bus.cycDone = 1'b1;
        tick();
        bus.cycDone = 1'b0;
        e = {1'b0, 1'b0, 9'o000, 1'b1, 2'b10, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL pf_clr got=%h exp=%h", obs, e);
        end
        tick();
    endtask

    task automatic test_new_req();
        logic [14:0] e;
        bus.trapReq1 = 1'b1;
        tick();
        bus.trapReq1 = 1'b0;
        bus.nicond   = 1'b1;
        tick();
        bus.nicond   = 1'b0;
        bus.trapReq2 = 1'b1;
        tick();
        bus.trapReq2 = 1'b0;
        e = {1'b1, 1'b0, 9'o421, 1'b1, 2'b00, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL nr_cycle got=%h exp=%h", obs, e);
        end
        bus.cycDone = 1'b1;
        tick();
        bus.cycDone = 1'b0;
        e = {1'b0, 1'b0, 9'o000, 1'b1, 2'b10, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL nr_clr got=%h exp=%h", obs, e);
        end
        tick();
        bus.nicond = 1'b1;
        tick();
        bus.nicond = 1'b0;
        e = {1'b0, 1'b1, 9'o422, 1'b1, 2'b00, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL nr_second got=%h exp=%h", obs, e);
        end
        bus.cycDone = 1'b1;
        tick();
        bus.cycDone = 1'b0;
        tick();
    endtask

    task automatic test_bypass_and_enable();
        logic [14:0] e;
        bus.user     = 1'b0;
        bus.trapReq1 = 1'b1;
        bus.nicond   = 1'b1;
        tick();
        bus.trapReq1 = 1'b0;
        bus.nicond   = 1'b0;
        e = {1'b1, 1'b0, 9'o421, 1'b0, 2'b00, 1'b0};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL bypass got=%h exp=%h", obs, e);
        end
        bus.cycDone = 1'b1;
        tick();
        bus.cycDone = 1'b0;
        tick();
        bus.trapReq1 = 1'b1;
        tick();
        bus.trapReq1 = 1'b0;
        bus.trapEn   = 1'b0;
        bus.nicond   = 1'b1;
        tick();
        checks++;
        if (obs !== 15'h0) begin
            failures++;
            $display("FAIL en_blocked got=%h exp=%h", obs, 15'h0);
        end
        bus.trapEn = 1'b1;
        tick();
        bus.nicond = 1'b0;
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL en_taken got=%h exp=%h", obs, e);
        end
        bus.cycDone = 1'b1;
        tick();
        bus.cycDone = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        logic [14:0] e;
        bus.user     = 1'b1;
        bus.trapReq2 = 1'b1;
        tick();
        bus.trapReq2 = 1'b0;
        bus.nicond   = 1'b1;
        tick();
        bus.nicond = 1'b0;
        e = {1'b0, 1'b1, 9'o422, 1'b1, 2'b00, 1'b0};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL to_cycle%0d got=%h exp=%h", i, obs, e);
            end
            if (i < 3) tick();
        end
        tick();
        e = {1'b0, 1'b0, 9'o000, 1'b1, 2'b00, 1'b1};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL to_hung got=%h exp=%h", obs, e);
        end
        tick();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL to_sticky got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] e;
        bus.trapReq1 = 1'b1;
        tick();
        bus.trapReq1 = 1'b0;
        bus.nicond   = 1'b1;
        tick();
        bus.nicond = 1'b0;
        e = {1'b1, 1'b0, 9'o421, 1'b1, 2'b00, 1'b1};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL rst_pre got=%h exp=%h", obs, e);
        end
        CROBAR       = 1'b1;
        bus.trapReq2 = 1'b1;
        tick();
        CROBAR       = 1'b0;
        bus.trapReq2 = 1'b0;
        checks++;
        if (obs !== 15'h0) begin
            failures++;
            $display("FAIL rst_mid got=%h exp=%h", obs, 15'h0);
        end
        tick();
        checks++;
        if (obs !== 15'h0) begin
            failures++;
            $display("FAIL rst_noclr got=%h exp=%h", obs, 15'h0);
        end
        bus.nicond = 1'b1;
        tick();
        bus.nicond = 1'b0;
        checks++;
        if (obs !== 15'h0) begin
            failures++;
            $display("FAIL rst_lost got=%h exp=%h", obs, 15'h0);
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_both();
        test_int_priority();
        test_page_fail();
        test_new_req();
        test_bypass_and_enable();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
